// File: rtl/logic_column_cfg_if.sv
`default_nettype none
// ============================================================================
// Module : logic_column_cfg_if
// Word-serial configuration handshake between a bitstream source and the column.
// Rev    : 1.0
// ============================================================================

interface logic_column_cfg_if #(
    parameter int CONFIG_WORD = 8
);
    logic                   config_start;
    logic [CONFIG_WORD-1:0] config_data;
    logic                   config_valid;
    logic                   config_ready;
    logic                   config_done;

    modport master (
        output config_start,
        output config_data,
        output config_valid,
        input  config_ready,
        input  config_done
    );

    modport slave (
        input  config_start,
        input  config_data,
        input  config_valid,
        output config_ready,
        output config_done
    );
endinterface

`default_nettype wire

// File: rtl/logic_column_cfg.sv
`default_nettype none
// ============================================================================
// Module : logic_column_cfg (with LogicTile)
// Column of TILES LogicTile rows fed by an on-block word-serial config loader.
// Rev    : 1.0
// ============================================================================

// Each of the 4*IO outputs is a flop selecting one of the 4*IO tile inputs
// (field = {invert, select}); two trailing bits give tile-wide hold and enable.
module LogicTile #(
    parameter int IO                = 6,
    parameter int TILE_CONFIG_WIDTH = 146
) (
    input  wire logic                         clock,
    input  wire logic                         nreset,
    input  wire logic [TILE_CONFIG_WIDTH-1:0] config_bits,
    input  wire logic [IO-1:0]                data_north_in,
    output logic      [IO-1:0]                data_north_out,
    input  wire logic [IO-1:0]                data_south_in,
    output logic      [IO-1:0]                data_south_out,
    input  wire logic [IO-1:0]                data_east_in,
    output logic      [IO-1:0]                data_east_out,
    input  wire logic [IO-1:0]                data_west_in,
    output logic      [IO-1:0]                data_west_out
);
    localparam int NOUT     = 4 * IO;
    localparam int SEL_W    = $clog2(NOUT);
    localparam int FIELD_W  = SEL_W + 1;
    localparam int HOLD_BIT = NOUT * FIELD_W;
    localparam int EN_BIT   = HOLD_BIT + 1;
    localparam logic [SEL_W:0] NOUT_W = (SEL_W + 1)'(NOUT);

    logic [NOUT-1:0] w_in_vec;
    logic [NOUT-1:0] w_out;
    logic [NOUT-1:0] out_d;
    logic [NOUT-1:0] out_q;

    assign w_in_vec = {data_west_in, data_east_in, data_south_in, data_north_in};

    always_comb begin
        out_d = out_q;
        if (!config_bits[HOLD_BIT]) begin
            for (int j = 0; j < NOUT; j++) begin
                // Out-of-range selects read as constant 0 before inversion.
                out_d[j] = config_bits[j*FIELD_W + SEL_W] ^
                           (({1'b0, config_bits[j*FIELD_W +: SEL_W]} < NOUT_W) ?
                            w_in_vec[config_bits[j*FIELD_W +: SEL_W]] : 1'b0);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign w_out          = out_q & {NOUT{config_bits[EN_BIT]}};
    assign data_north_out = w_out[IO-1:0];
    assign data_south_out = w_out[2*IO-1:IO];
    assign data_east_out  = w_out[3*IO-1:2*IO];
    assign data_west_out  = w_out[4*IO-1:3*IO];
endmodule

module logic_column_cfg #(
    parameter int TILES             = 3,
    parameter int IO                = 6,
    parameter int TILE_CONFIG_WIDTH = 146,
    parameter int CONFIG_WORD       = 8
) (
    input  wire logic                  clock,
    input  wire logic                  nreset,
    input  wire logic [IO-1:0]         data_north_in,
    output logic      [IO-1:0]         data_north_out,
    input  wire logic [IO-1:0]         data_south_in,
    output logic      [IO-1:0]         data_south_out,
    input  wire logic [TILES*IO-1:0]   data_east_in,
    output logic      [TILES*IO-1:0]   data_east_out,
    input  wire logic [TILES*IO-1:0]   data_west_in,
    output logic      [TILES*IO-1:0]   data_west_out,
    logic_column_cfg_if.slave          cfg_if
);
    localparam int TOTAL  = TILES * TILE_CONFIG_WIDTH;
    localparam int NWORDS = (TOTAL + CONFIG_WORD - 1) / CONFIG_WORD;
    localparam int SR_W   = NWORDS * CONFIG_WORD;
    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [SR_W-1:0]   sr_q;
    logic [SR_W-1:0]   sr_d;
    logic [SR_W-1:0]   w_sr_shifted;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              w_ready;
    logic              w_done;
    logic              w_tile_nreset;

    // Words enter at the top so the first accepted word ends up at bit 0.
    generate
        if (NWORDS == 1) begin : g_single_word
            assign w_sr_shifted = cfg_if.config_data;
        end else begin : g_multi_word
            assign w_sr_shifted = {cfg_if.config_data, sr_q[SR_W-1:CONFIG_WORD]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        w_ready = 1'b0;
        w_done  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_if.config_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                w_ready = 1'b1;
                if (cfg_if.config_valid) begin
                    sr_d  = w_sr_shifted;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (cfg_if.config_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cfg_if.config_ready = w_ready;
    assign cfg_if.config_done  = w_done;
    assign w_tile_nreset       = nreset & w_done;

    logic [IO-1:0] w_n_in  [TILES];
    logic [IO-1:0] w_s_in  [TILES];
    logic [IO-1:0] w_n_out [TILES];
    logic [IO-1:0] w_s_out [TILES];
    logic [IO-1:0] w_e_out [TILES];
    logic [IO-1:0] w_w_out [TILES];

    generate
        for (genvar k = 0; k < TILES; k++) begin : g_tile
            if (k == TILES - 1) begin : g_north_edge
                assign w_n_in[k] = data_north_in;
            end else begin : g_north_link
                assign w_n_in[k] = w_s_out[k+1];
            end

            if (k == 0) begin : g_south_edge
                assign w_s_in[k] = data_south_in;
            end else begin : g_south_link
                assign w_s_in[k] = w_n_out[k-1];
            end

            LogicTile #(
                .IO                (IO),
                .TILE_CONFIG_WIDTH (TILE_CONFIG_WIDTH)
            ) u_tile (
                .clock          (clock),
                .nreset         (w_tile_nreset),
                .config_bits    (sr_q[k*TILE_CONFIG_WIDTH +: TILE_CONFIG_WIDTH]),
                .data_north_in  (w_n_in[k]),
                .data_north_out (w_n_out[k]),
                .data_south_in  (w_s_in[k]),
                .data_south_out (w_s_out[k]),
                .data_east_in   (data_east_in[k*IO +: IO]),
                .data_east_out  (w_e_out[k]),
                .data_west_in   (data_west_in[k*IO +: IO]),
                .data_west_out  (w_w_out[k])
            );

            assign data_east_out[k*IO +: IO] = w_done ? w_e_out[k] : '0;
            assign data_west_out[k*IO +: IO] = w_done ? w_w_out[k] : '0;
        end
    endgenerate

    assign data_north_out = w_done ? w_n_out[TILES-1] : '0;
    assign data_south_out = w_done ? w_s_out[0]       : '0;
endmodule

`default_nettype wire

// File: tb/tb_logic_column_cfg.sv
`default_nettype none
// ============================================================================
// Module : tb_logic_column_cfg
// Random bitstreams and fabric traffic compared against a bit-array column model.
// Rev    : 1.0
// ============================================================================

module tb_logic_column_cfg;
    localparam int TILES    = 3;
    localparam int IO       = 6;
    localparam int TCW      = 146;
    localparam int CW       = 8;
    localparam int TOTAL    = TILES * TCW;
    localparam int NWORDS   = (TOTAL + CW - 1) / CW;
    localparam int SR_W     = NWORDS * CW;
    localparam int NO       = 4 * IO;
    localparam int SEL_W    = 5;
    localparam int FW       = SEL_W + 1;
    localparam int HOLD_BIT = NO * FW;
    localparam int EN_BIT   = HOLD_BIT + 1;
    localparam int CW2      = 146;

    logic                clk = 1'b0;
    logic                nreset;
    logic [IO-1:0]       n_in, n_out, s_in, s_out;
    logic [TILES*IO-1:0] e_in, e_out, w_in, w_out;
    logic [IO-1:0]       n_in2, n_out2, s_in2, s_out2, e_in2, e_out2, w_in2, w_out2;

    logic_column_cfg_if #(.CONFIG_WORD(CW))  cfg_if  ();
    logic_column_cfg_if #(.CONFIG_WORD(CW2)) cfg_if2 ();

    logic_column_cfg #(.TILES(TILES), .IO(IO), .TILE_CONFIG_WIDTH(TCW), .CONFIG_WORD(CW)) dut (
        .clock(clk), .nreset(nreset),
        .data_north_in(n_in), .data_north_out(n_out),
        .data_south_in(s_in), .data_south_out(s_out),
        .data_east_in(e_in),  .data_east_out(e_out),
        .data_west_in(w_in),  .data_west_out(w_out),
        .cfg_if(cfg_if)
    );

    logic_column_cfg #(.TILES(1), .IO(IO), .TILE_CONFIG_WIDTH(TCW), .CONFIG_WORD(CW2)) dut2 (
        .clock(clk), .nreset(nreset),
        .data_north_in(n_in2), .data_north_out(n_out2),
        .data_south_in(s_in2), .data_south_out(s_out2),
        .data_east_in(e_in2),  .data_east_out(e_out2),
        .data_west_in(w_in2),  .data_west_out(w_out2),
        .cfg_if(cfg_if2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: loader as flags + word index, tiles as output-bit arrays.
    bit              m_loading, m_done, m_accepted;
    int              m_cnt;
    logic [SR_W-1:0] m_bits;
    logic [NO-1:0]   m_q [TILES];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NO-1:0] tile_out(input int k);
        logic [TCW-1:0] c;
        c = m_bits[k*TCW +: TCW];
        return m_q[k] & {NO{c[EN_BIT]}};
    endfunction

    task automatic model_update();
        logic [NO-1:0] nq [TILES];
        for (int k = 0; k < TILES; k++) begin
            logic [TCW-1:0] c;
            logic [IO-1:0]  ni, si;
            logic [NO-1:0]  vec, t;
            int             sel;
            c = m_bits[k*TCW +: TCW];
            if (k == TILES - 1) ni = n_in;
            else begin t = tile_out(k + 1); ni = t[2*IO-1:IO]; end
            if (k == 0) si = s_in;
            else begin t = tile_out(k - 1); si = t[IO-1:0]; end
            vec = {w_in[k*IO +: IO], e_in[k*IO +: IO], si, ni};
            if (!nreset || !m_done) nq[k] = '0;
            else if (c[HOLD_BIT]) nq[k] = m_q[k];
            else begin
                for (int j = 0; j < NO; j++) begin
                    sel = int'(c[j*FW +: SEL_W]);
                    nq[k][j] = c[j*FW + SEL_W] ^ ((sel < NO) ? vec[sel] : 1'b0);
                end
            end
        end
        for (int k = 0; k < TILES; k++) m_q[k] = nq[k];

        m_accepted = 1'b0;
        if (!nreset) begin
            m_loading = 1'b0; m_done = 1'b0; m_cnt = 0; m_bits = '0;
        end else if (m_loading) begin
            if (cfg_if.config_valid) begin
                m_bits[m_cnt*CW +: CW] = cfg_if.config_data;
                m_cnt++;
                m_accepted = 1'b1;
                if (m_cnt == NWORDS) begin m_loading = 1'b0; m_done = 1'b1; end
            end
        end else if (cfg_if.config_start) begin
            m_loading = 1'b1; m_done = 1'b0; m_cnt = 0;
        end
    endtask

    task automatic tick();
        logic [NO-1:0]       t;
        logic [TILES*IO-1:0] ee, ww;
        logic [IO-1:0]       nn, ss;
        @(posedge clk);
        model_update();
        #1;
        ee = '0; ww = '0; nn = '0; ss = '0;
        if (m_done) begin
            for (int k = 0; k < TILES; k++) begin
                t = tile_out(k);
                ee[k*IO +: IO] = t[3*IO-1:2*IO];
                ww[k*IO +: IO] = t[4*IO-1:3*IO];
            end
            t = tile_out(TILES - 1); nn = t[IO-1:0];
            t = tile_out(0);         ss = t[2*IO-1:IO];
        end
        check_eq("ready", 256'(cfg_if.config_ready), 256'(m_loading));
        check_eq("done",  256'(cfg_if.config_done),  256'(m_done));
        check_eq("north_out", 256'(n_out), 256'(nn));
        check_eq("south_out", 256'(s_out), 256'(ss));
        check_eq("east_out",  256'(e_out), 256'(ee));
        check_eq("west_out",  256'(w_out), 256'(ww));
        n_in = IO'($urandom);
        s_in = IO'($urandom);
        e_in = (TILES*IO)'($urandom);
        w_in = (TILES*IO)'($urandom);
    endtask

    function automatic logic [SR_W-1:0] make_stream();
        logic [SR_W-1:0] s;
        for (int i = 0; i < SR_W; i++) s[i] = 1'($urandom_range(0, 1));
        for (int k = 0; k < TILES; k++) begin
            s[k*TCW + HOLD_BIT] = ($urandom_range(0, 7) == 0);
            s[k*TCW + EN_BIT]   = 1'b1;
        end
        return s;
    endfunction

    // mode 0: valid always high, 1: pattern 1,0,0, 2: random
    task automatic load_stream(input logic [SR_W-1:0] s, input int mode, input int start_at,
                               input string tag);
        int idx = 0;
        int cyc = 0;
        int rdy = 0;
        bit pulsed = 1'b0;
        cfg_if.config_start = 1'b1;
        tick();
        cfg_if.config_start = 1'b0;
        if (cfg_if.config_ready) rdy++;
        while (idx < NWORDS && cyc < 400) begin
            case (mode)
                0:       cfg_if.config_valid = 1'b1;
                1:       cfg_if.config_valid = ((cyc % 3) == 0);
                default: cfg_if.config_valid = 1'($urandom_range(0, 1));
            endcase
            cfg_if.config_data = s[idx*CW +: CW];
            if (idx == start_at && !pulsed) begin
                cfg_if.config_start = 1'b1;
                pulsed = 1'b1;
            end else begin
                cfg_if.config_start = 1'b0;
            end
            tick();
            if (m_accepted) idx++;
            if (cfg_if.config_ready) rdy++;
            cyc++;
        end
        cfg_if.config_valid = 1'b0;
        cfg_if.config_start = 1'b0;
        check_eq({tag, "_words"}, 256'(idx), 256'(NWORDS));
        check_eq({tag, "_done"}, 256'(cfg_if.config_done), 256'(1));
        if (mode == 0) check_eq({tag, "_ready_cycles"}, 256'(rdy), 256'(NWORDS));
        for (int k = 0; k < TILES; k++)
            check_eq({tag, "_tile_cfg"}, 256'(dut.sr_q[k*TCW +: TCW]), 256'(s[k*TCW +: TCW]));
    endtask

    initial begin
        logic [SR_W-1:0] s;
        logic [CW2-1:0]  c2;
        int              idx;
        int              cyc;

        nreset = 1'b0;
        cfg_if.config_start = 1'b0; cfg_if.config_valid = 1'b0; cfg_if.config_data = '0;
        cfg_if2.config_start = 1'b0; cfg_if2.config_valid = 1'b0; cfg_if2.config_data = '0;
        n_in = '0; s_in = '0; e_in = '0; w_in = '0;
        n_in2 = '0; s_in2 = '0; e_in2 = '0; w_in2 = '0;
        m_loading = 1'b0; m_done = 1'b0; m_accepted = 1'b0; m_cnt = 0; m_bits = '0;
        for (int k = 0; k < TILES; k++) m_q[k] = '0;

        tick();
        tick();
        nreset = 1'b1;
        repeat (10) tick();

        s = make_stream();
        load_stream(s, 0, -1, "full");
        check_eq("full_tile1_bits", 256'(dut.sr_q[291:146]), 256'(s[291:146]));
        repeat (100) tick();

        s = make_stream();
        load_stream(s, 1, -1, "backpressure");
        repeat (60) tick();

        s = make_stream();
        load_stream(s, 0, 20, "start_midload");
        repeat (30) tick();

        s = make_stream();
        load_stream(s, 2, NWORDS - 1, "start_lastword");
        repeat (30) tick();

        // Abort a load with reset after 30 words.
        cfg_if.config_start = 1'b1;
        tick();
        cfg_if.config_start = 1'b0;
        idx = 0; cyc = 0;
        while (idx < 30 && cyc < 100) begin
            cfg_if.config_valid = 1'b1;
            cfg_if.config_data  = CW'($urandom);
            tick();
            if (m_accepted) idx++;
            cyc++;
        end
        cfg_if.config_valid = 1'b0;
        nreset = 1'b0;
        tick();
        check_eq("rst_sr_zero", 256'(|dut.sr_q), 256'(0));
        nreset = 1'b1;
        repeat (3) tick();
        s = make_stream();
        load_stream(s, 0, -1, "after_reset");
        repeat (50) tick();

        // Single tile, single-word bitstream: pass each input straight through.
        check_eq("t1_idle_north", 256'(n_out2), 256'(0));
        c2 = '0;
        for (int j = 0; j < NO; j++) c2[j*FW +: FW] = FW'(j);
        c2[EN_BIT] = 1'b1;
        cfg_if2.config_start = 1'b1;
        tick();
        cfg_if2.config_start = 1'b0;
        check_eq("t1_ready", 256'(cfg_if2.config_ready), 256'(1));
        check_eq("t1_done_early", 256'(cfg_if2.config_done), 256'(0));
        cfg_if2.config_valid = 1'b1;
        cfg_if2.config_data  = c2;
        tick();
        cfg_if2.config_valid = 1'b0;
        check_eq("t1_done", 256'(cfg_if2.config_done), 256'(1));
        check_eq("t1_ready_off", 256'(cfg_if2.config_ready), 256'(0));
        check_eq("t1_cfg", 256'(dut2.sr_q), 256'(c2));
        repeat (4) begin
            n_in2 = IO'($urandom); s_in2 = IO'($urandom);
            e_in2 = IO'($urandom); w_in2 = IO'($urandom);
            tick();
            check_eq("t1_north", 256'(n_out2), 256'(n_in2));
            check_eq("t1_south", 256'(s_out2), 256'(s_in2));
            check_eq("t1_east",  256'(e_out2), 256'(e_in2));
            check_eq("t1_west",  256'(w_out2), 256'(w_in2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
